// File: rtl/arb_rr_mux.sv
// arb_rr_mux: round-robin arbiter feeding a one-hot data mux and a single
// registered output stage shared by WIDTH valid/ready requesters.
// Optional packet locking is compiled in with `define ARB_RR_MUX_LOCK_EN:
// adds req_lst/out_lst and holds the grant on one requester until its last beat.
// mux_oht_tree is the one-hot selector used by the arbiter.

module mux_oht_tree #(
  parameter type DAT_T          = logic [8-1:0],
  parameter int  WIDTH          = 16,
  parameter int  SPLIT          = 4,
  parameter int  IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] sel,
  input  DAT_T [WIDTH-1:0] dat,
  output DAT_T             out
);

  // Number of leaf groups; the input is padded up to NG*SPLIT entries.
  localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;

  DAT_T [NG*SPLIT-1:0] masked;

  // Zero every unselected (or padding) entry so the result is a plain OR.
  for (genvar gi = 0; gi < NG*SPLIT; gi++) begin : g_mask
    if (gi < WIDTH) begin : g_real
      assign masked[gi] = sel[gi] ? dat[gi] : '0;
    end else begin : g_pad
      assign masked[gi] = '0;
    end
  end

  if (IMPLEMENTATION == 0) begin : g_tree
    DAT_T [NG-1:0] grp;

    // Two-level OR tree: SPLIT-wide leaf groups, then a final reduction.
    always_comb begin
      grp = '0;
      out = '0;
      for (int g = 0; g < NG; g++) begin
        for (int j = 0; j < SPLIT; j++) begin
          grp[g] = grp[g] | masked[g*SPLIT+j];
        end
        out = out | grp[g];
      end
    end
  end else begin : g_flat
    // Single flat AND-OR across all requesters.
    always_comb begin
      out = '0;
      for (int i = 0; i < WIDTH; i++) begin
        out = out | masked[i];
      end
    end
  end

endmodule

module arb_rr_mux #(
  parameter type DAT_T          = logic [8-1:0],
  parameter int  WIDTH          = 16,
  parameter int  SPLIT          = 4,
  parameter int  IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req_vld,
  input  DAT_T [WIDTH-1:0]         req_dat,
`ifdef ARB_RR_MUX_LOCK_EN
  input  logic [WIDTH-1:0]         req_lst,
  output logic                     out_lst,
`endif
  output logic [WIDTH-1:0]         req_rdy,
  output logic [WIDTH-1:0]         gnt,
  output logic                     out_vld,
  output DAT_T                     out_dat,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  input  logic                     out_rdy
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] ptr_reg;
  logic [WIDTH-1:0] mask_hi;
  logic [WIDTH-1:0] masked_req;
  logic [WIDTH-1:0] rr_gnt;
  logic [WIDTH-1:0] ptr_rot;
  logic [IDX_W-1:0] gnt_idx;
  logic             load;
  logic             xfer;
  logic             ptr_adv;
  DAT_T             mux_out;

  logic             out_vld_reg;
  DAT_T             out_dat_reg;
  logic [IDX_W-1:0] out_idx_reg;

  // The output stage can accept a new beat when empty or being drained.
  assign load = ~out_vld_reg | out_rdy;

  // Round-robin pick: lowest request at or above ptr, else lowest overall.
  // ptr is one-hot, so ~(ptr-1) masks in every position >= ptr.
  always_comb begin
    mask_hi    = ~(ptr_reg - WIDTH'(1));
    masked_req = req_vld & mask_hi;
    if (|masked_req) begin
      rr_gnt = masked_req & (~masked_req + WIDTH'(1));
    end else begin
      rr_gnt = req_vld & (~req_vld + WIDTH'(1));
    end
  end

`ifdef ARB_RR_MUX_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] lock_reg;
  logic [WIDTH-1:0] lock_next;
  logic             lst_sel;
  logic             out_lst_reg;

  // While locked the grant is pinned to the packet owner, even if it idles.
  assign gnt     = (state_reg == LOCK) ? lock_reg : rr_gnt;
  assign lst_sel = |(gnt & req_lst);
  // Rotate priority only once a whole packet has gone through.
  assign ptr_adv = lst_sel;
  assign out_lst = out_lst_reg;

  // Packet lock state and owner registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lock_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lock_reg  <= lock_next;
    end
  end

  // Enter LOCK on a non-final beat, leave on the final beat of the packet.
  always_comb begin
    state_next = state_reg;
    lock_next  = lock_reg;
    case (state_reg)
      IDLE: begin
        if (xfer && !lst_sel) begin
          state_next = LOCK;
          lock_next  = gnt;
        end
      end
      LOCK: begin
        if (xfer && lst_sel) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Last-beat flag travels with the data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_lst_reg <= 1'b0;
    end else if (xfer) begin
      out_lst_reg <= lst_sel;
    end
  end
`else
  assign gnt     = rr_gnt;
  assign ptr_adv = 1'b1;
`endif

  // A beat moves only if the granted requester is actually valid.
  assign xfer    = load & (|(gnt & req_vld));
  assign req_rdy = gnt & {WIDTH{load}};
  assign ptr_rot = {gnt[WIDTH-2:0], gnt[WIDTH-1]};

  // One-hot to binary index of the granted requester.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt[i]) begin
        gnt_idx = gnt_idx | IDX_W'(i);
      end
    end
  end

  mux_oht_tree #(
    .DAT_T          (DAT_T),
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_mux (
    .sel (gnt),
    .dat (req_dat),
    .out (mux_out)
  );

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_reg <= 1'b0;
      out_dat_reg <= '0;
      out_idx_reg <= '0;
      ptr_reg     <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      if (load) begin
        out_vld_reg <= xfer;
        if (xfer) begin
          out_dat_reg <= mux_out;
          out_idx_reg <= gnt_idx;
        end
      end
      if (xfer && ptr_adv) begin
        ptr_reg <= ptr_rot;
      end
    end
  end

  assign out_vld = out_vld_reg;
  assign out_dat = out_dat_reg;
  assign out_idx = out_idx_reg;

endmodule
